// File: rtl/guess_judge_fsm.sv
// Judge for the up/down number-guessing game.
// Picks a secret (LFSR rejection sampling or a clamped fixed value), takes guesses
// over a valid/ready handshake, and returns up/down/correct hints with round counters.
// It declares success after WIN_TARGET correct rounds, or failure after MAX_WRONG
// wrong guesses in a single round.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   start            one-cycle pulse; clears game state and draws a new secret
//   mode_fixed       1: secret = min(fixed_secret, MAX_VAL); 0: LFSR draw
//   fixed_secret     fixed secret value
//   guess_valid/data guess handshake from keypad decoder
//   guess_ready      high while a guess can be accepted
//   hint             none/up/down/correct code, held between pulses
//   hint_valid       one-cycle pulse when hint/counters update
//   guess_err        one-cycle pulse for an out-of-range guess
//   correct_cnt      correct rounds this game
//   wrong_cnt        wrong guesses in the current round
//   success, fail    held terminal flags
//   secret_dbg       current secret
module guess_judge_fsm #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned MAX_VAL    = 9,
  parameter int unsigned WIN_TARGET = 3,
  parameter int unsigned MAX_WRONG  = 9,
  parameter int unsigned CNT_W      = 4,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode_fixed,
  input  logic [DATA_W-1:0] fixed_secret,
  input  logic              guess_valid,
  input  logic [DATA_W-1:0] guess_data,
  output logic              guess_ready,
  output logic [1:0]        hint,
  output logic              hint_valid,
  output logic              guess_err,
  output logic [CNT_W-1:0]  correct_cnt,
  output logic [CNT_W-1:0]  wrong_cnt,
  output logic              success,
  output logic              fail,
  output logic [DATA_W-1:0] secret_dbg
);

  localparam logic [DATA_W-1:0] MAX_V     = DATA_W'(MAX_VAL);
  localparam logic [CNT_W-1:0]  WIN_T     = CNT_W'(WIN_TARGET);
  localparam logic [CNT_W-1:0]  WRONG_T   = CNT_W'(MAX_WRONG);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  // Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
  localparam logic [15:0]       LFSR_TAPS = 16'hB400;

  localparam logic [1:0] HINT_NONE = 2'd0;
  localparam logic [1:0] HINT_UP   = 2'd1;
  localparam logic [1:0] HINT_DOWN = 2'd2;
  localparam logic [1:0] HINT_OK   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_JUDGE,
    S_WIN,
    S_LOSE
  } state_e;

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [DATA_W-1:0]  secret_q, secret_d;
  logic [DATA_W-1:0]  guess_q, guess_d;
  logic [1:0]         hint_q, hint_d;
  logic               hint_valid_q, hint_valid_d;
  logic               guess_err_q, guess_err_d;
  logic [CNT_W-1:0]   correct_q, correct_d;
  logic [CNT_W-1:0]   wrong_q, wrong_d;
  logic               success_q, success_d;
  logic               fail_q, fail_d;
  logic               ready_q, ready_d;

  logic [DATA_W-1:0]  candidate;
  logic [DATA_W-1:0]  fixed_clamped;
  logic [CNT_W-1:0]   correct_inc;
  logic [CNT_W-1:0]   wrong_inc;

  assign candidate     = lfsr_q[DATA_W-1:0];
  assign fixed_clamped = (fixed_secret > MAX_V) ? MAX_V : fixed_secret;
  assign correct_inc   = correct_q + CNT_ONE;
  assign wrong_inc     = wrong_q + CNT_ONE;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      secret_q     <= '0;
      guess_q      <= '0;
      hint_q       <= HINT_NONE;
      hint_valid_q <= 1'b0;
      guess_err_q  <= 1'b0;
      correct_q    <= '0;
      wrong_q      <= '0;
      success_q    <= 1'b0;
      fail_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      secret_q     <= secret_d;
      guess_q      <= guess_d;
      hint_q       <= hint_d;
      hint_valid_q <= hint_valid_d;
      guess_err_q  <= guess_err_d;
      correct_q    <= correct_d;
      wrong_q      <= wrong_d;
      success_q    <= success_d;
      fail_q       <= fail_d;
      ready_q      <= ready_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state_q;
    secret_d     = secret_q;
    guess_d      = guess_q;
    hint_d       = hint_q;
    hint_valid_d = 1'b0;
    guess_err_d  = 1'b0;
    correct_d    = correct_q;
    wrong_d      = wrong_q;
    success_d    = success_q;
    fail_d       = fail_q;
    // LFSR free-runs in every state
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    if (start) begin
      // start wins over a same-cycle handshake; that guess is dropped
      hint_d    = HINT_NONE;
      correct_d = '0;
      wrong_d   = '0;
      success_d = 1'b0;
      fail_d    = 1'b0;
      state_d   = S_ARM;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ARM: begin
          if (mode_fixed) begin
            secret_d = fixed_clamped;
            state_d  = S_WAIT;
          end else if (candidate <= MAX_V) begin
            // rejection sampling keeps the draw uniform over 0..MAX_VAL
            secret_d = candidate;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (guess_valid && ready_q) begin
            if (guess_data > MAX_V) begin
              guess_err_d = 1'b1;
            end else begin
              guess_d = guess_data;
              state_d = S_JUDGE;
            end
          end
        end
        S_JUDGE: begin
          hint_valid_d = 1'b1;
          if (guess_q == secret_q) begin
            hint_d    = HINT_OK;
            correct_d = correct_inc;
            wrong_d   = '0;
            if (correct_inc == WIN_T) begin
              success_d = 1'b1;
              state_d   = S_WIN;
            end else begin
              state_d = S_ARM;
            end
          end else begin
            hint_d  = (secret_q > guess_q) ? HINT_UP : HINT_DOWN;
            wrong_d = wrong_inc;
            if (wrong_inc == WRONG_T) begin
              fail_d  = 1'b1;
              state_d = S_LOSE;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WIN, S_LOSE: ;
        default: state_d = S_IDLE;
      endcase
    end

    ready_d = (state_d == S_WAIT);
  end

  assign guess_ready = ready_q;
  assign hint        = hint_q;
  assign hint_valid  = hint_valid_q;
  assign guess_err   = guess_err_q;
  assign correct_cnt = correct_q;
  assign wrong_cnt   = wrong_q;
  assign success     = success_q;
  assign fail        = fail_q;
  assign secret_dbg  = secret_q;

endmodule

// File: tb/tb_guess_judge_fsm.sv
// Randomised and directed bench for guess_judge_fsm with a flag-based game model.
module tb_guess_judge_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       mode_fixed = 1'b0;
  logic [3:0] fixed_secret = 4'd0;
  logic       guess_valid = 1'b0;
  logic [3:0] guess_data = 4'd0;
  logic       guess_ready;
  logic [1:0] fb_hint;
  logic       fb_hint_valid;
  logic       guess_err;
  logic [3:0] correct_cnt;
  logic [3:0] wrong_cnt;
  logic       success;
  logic       fail;
  logic [3:0] secret_dbg;

  int checks = 0;
  int errors = 0;

  guess_judge_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .mode_fixed   (mode_fixed),
    .fixed_secret (fixed_secret),
    .guess_valid  (guess_valid),
    .guess_data   (guess_data),
    .guess_ready  (guess_ready),
    .hint         (fb_hint),
    .hint_valid   (fb_hint_valid),
    .guess_err    (guess_err),
    .correct_cnt  (correct_cnt),
    .wrong_cnt    (wrong_cnt),
    .success      (success),
    .fail         (fail),
    .secret_dbg   (secret_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- game model ----------------
  logic [15:0] m_lfsr = 16'hACE1;
  int  m_secret = 0, m_pguess = 0, m_hint = 0, m_correct = 0, m_wrong = 0;
  bit  m_arming = 0, m_accepting = 0, m_pending = 0;
  bit  m_win = 0, m_lose = 0, m_hv = 0, m_err = 0;

  function automatic logic [15:0] galois(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_secret = 0; m_pguess = 0; m_hint = 0; m_correct = 0; m_wrong = 0;
    m_arming = 0; m_accepting = 0; m_pending = 0;
    m_win = 0; m_lose = 0; m_hv = 0; m_err = 0;
  endtask

  task automatic model_step();
    int cand;
    cand = int'(m_lfsr[3:0]);
    m_hv = 0;
    m_err = 0;
    if (start) begin
      m_hint = 0; m_correct = 0; m_wrong = 0; m_win = 0; m_lose = 0;
      m_arming = 1; m_accepting = 0; m_pending = 0;
    end else if (m_arming) begin
      if (mode_fixed) begin
        m_secret = (int'(fixed_secret) > 9) ? 9 : int'(fixed_secret);
        m_arming = 0; m_accepting = 1;
      end else if (cand <= 9) begin
        m_secret = cand;
        m_arming = 0; m_accepting = 1;
      end
    end else if (m_accepting && guess_valid) begin
      if (int'(guess_data) > 9) m_err = 1;
      else begin
        m_pguess = int'(guess_data);
        m_pending = 1; m_accepting = 0;
      end
    end else if (m_pending) begin
      m_pending = 0;
      m_hv = 1;
      if (m_pguess == m_secret) begin
        m_hint = 3; m_correct++; m_wrong = 0;
        if (m_correct == 3) m_win = 1; else m_arming = 1;
      end else begin
        m_hint = (m_secret > m_pguess) ? 1 : 2;
        m_wrong++;
        if (m_wrong == 9) m_lose = 1; else m_accepting = 1;
      end
    end
    m_lfsr = galois(m_lfsr);
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    chk("m_guess_ready", int'(guess_ready),   int'(m_accepting));
    chk("m_hint",        int'(fb_hint),       m_hint);
    chk("m_hint_valid",  int'(fb_hint_valid), int'(m_hv));
    chk("m_guess_err",   int'(guess_err),     int'(m_err));
    chk("m_correct_cnt", int'(correct_cnt),   m_correct);
    chk("m_wrong_cnt",   int'(wrong_cnt),     m_wrong);
    chk("m_success",     int'(success),       int'(m_win));
    chk("m_fail",        int'(fail),          int'(m_lose));
    chk("m_secret_dbg",  int'(secret_dbg),    m_secret);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(input bit restart_on_end, output bit ok);
    int n;
    n = 0;
    ok = 1;
    while (guess_ready !== 1'b1) begin
      if (n == 200) begin
        chk("ready_timeout", 0, 1);
        ok = 0;
        return;
      end
      if (restart_on_end && (success || fail)) do_start();
      else tick();
      n++;
    end
  endtask

  task automatic guess_and_check(input string nm, input int g, input int eh,
                                 input int ec, input int ew);
    bit ok;
    wait_ready(1'b0, ok);
    if (!ok) return;
    guess_valid = 1'b1;
    guess_data  = 4'(g);
    tick();
    guess_valid = 1'b0;
    chk({nm, "_hv_early"}, int'(fb_hint_valid), 0);
    chk({nm, "_rdy_drop"}, int'(guess_ready),   0);
    tick();
    chk({nm, "_hv"},      int'(fb_hint_valid), 1);
    chk({nm, "_hint"},    int'(fb_hint),       eh);
    chk({nm, "_correct"}, int'(correct_cnt),   ec);
    chk({nm, "_wrong"},   int'(wrong_cnt),     ew);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit ok;
    int g, rounds, iters;

    chk("lfsr_model_pin", int'(galois(16'hACE1)), 16'hE270);

    // reset, then idle block must ignore guesses
    repeat (3) tick();
    chk("rst_ready",   int'(guess_ready), 0);
    chk("rst_hint",    int'(fb_hint),     0);
    chk("rst_correct", int'(correct_cnt), 0);
    chk("rst_success", int'(success),     0);
    chk("rst_secret",  int'(secret_dbg),  0);
    reset = 1'b1;
    guess_valid = 1'b1;
    guess_data  = 4'd5;
    repeat (5) begin
      tick();
      chk("idle_hv",    int'(fb_hint_valid), 0);
      chk("idle_wrong", int'(wrong_cnt),     0);
    end
    guess_valid = 1'b0;

    // fixed secret 7: up, down, correct, then win
    mode_fixed   = 1'b1;
    fixed_secret = 4'd7;
    do_start();
    guess_and_check("g3", 3, 1, 0, 1);
    guess_and_check("g9", 9, 2, 0, 2);
    guess_and_check("g7a", 7, 3, 1, 0);
    guess_and_check("g7b", 7, 3, 2, 0);
    guess_and_check("g7c", 7, 3, 3, 0);
    chk("win_success", int'(success),     1);
    chk("win_ready",   int'(guess_ready), 0);
    guess_valid = 1'b1;
    guess_data  = 4'd7;
    repeat (4) begin
      tick();
      chk("win_ignore_cnt", int'(correct_cnt),   3);
      chk("win_ignore_hv",  int'(fb_hint_valid), 0);
      chk("win_ignore_err", int'(guess_err),     0);
    end
    guess_valid = 1'b0;

    // nine wrong guesses lose the game
    do_start();
    for (int i = 1; i <= 9; i++) guess_and_check("lose", 0, 1, 0, i);
    chk("lose_fail",  int'(fail),        1);
    chk("lose_ready", int'(guess_ready), 0);
    do_start();
    chk("restart_hint",  int'(fb_hint),     0);
    chk("restart_wrong", int'(wrong_cnt),   0);
    chk("restart_fail",  int'(fail),        0);
    chk("restart_ready", int'(guess_ready), 0);

    // out-of-range guess only pulses guess_err
    guess_and_check("pre_err", 3, 1, 0, 1);
    wait_ready(1'b0, ok);
    guess_valid = 1'b1;
    guess_data  = 4'd12;
    tick();
    guess_valid = 1'b0;
    chk("err_pulse", int'(guess_err),     1);
    chk("err_ready", int'(guess_ready),   1);
    chk("err_hint",  int'(fb_hint),       1);
    chk("err_wrong", int'(wrong_cnt),     1);
    chk("err_hv",    int'(fb_hint_valid), 0);
    tick();
    chk("err_end", int'(guess_err), 0);

    // start in the same cycle as a handshake drops the guess
    wait_ready(1'b0, ok);
    guess_valid = 1'b1;
    guess_data  = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    guess_valid = 1'b0;
    chk("sg_wrong", int'(wrong_cnt),   0);
    chk("sg_hint",  int'(fb_hint),     0);
    chk("sg_ready", int'(guess_ready), 0);
    tick();
    chk("sg_no_hv", int'(fb_hint_valid), 0);
    chk("sg_wait",  int'(guess_ready),   1);

    // fixed secret above MAX_VAL is clamped
    fixed_secret = 4'd14;
    do_start();
    wait_ready(1'b0, ok);
    chk("clamp_secret", int'(secret_dbg), 9);

    // reset while a guess is being judged
    guess_and_check("pre_rst", 2, 1, 0, 1);
    wait_ready(1'b0, ok);
    guess_valid = 1'b1;
    guess_data  = 4'd9;
    tick();
    reset = 1'b0;
    guess_valid = 1'b0;
    #1;
    chk("jrst_hint",   int'(fb_hint),     0);
    chk("jrst_wrong",  int'(wrong_cnt),   0);
    chk("jrst_ready",  int'(guess_ready), 0);
    chk("jrst_secret", int'(secret_dbg),  0);
    tick();
    chk("jrst_hv", int'(fb_hint_valid), 0);
    reset = 1'b1;
    repeat (2) tick();

    // random LFSR games, driven mostly by correct guesses
    mode_fixed = 1'b0;
    do_start();
    rounds = 0;
    iters  = 0;
    while (rounds < 1000 && iters < 4000) begin
      iters++;
      wait_ready(1'b1, ok);
      if (!ok) break;
      chk("rand_secret_range", int'(secret_dbg <= 4'd9), 1);
      if ($urandom_range(0, 3) == 0) g = int'($urandom_range(0, 15));
      else g = int'(secret_dbg);
      if (g == int'(secret_dbg)) rounds++;
      guess_valid = 1'b1;
      guess_data  = 4'(g);
      tick();
      guess_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    chk("rand_rounds", rounds, 1000);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/guess_judge_fsm.md
Name: guess_judge_fsm

Overview:
- Parametrised, fully synchronous judge for the up/down number-guessing game.
- Draws a secret value from an internal LFSR, or takes a fixed value, then accepts guesses over a valid/ready handshake.
- For each guess it returns an up/down/correct hint and tracks correct and wrong counts. It declares success or failure at configurable thresholds.
- Sits between the keypad decoder, which supplies binary guesses, and the display/LED driver, which consumes hints, counters and flags.

Parameters:
- DATA_W, 4, width of guess and secret.
- MAX_VAL, 9, largest legal secret/guess value; must be ≤ 2^DATA_W-1.
- WIN_TARGET, 3, correct rounds needed for success.
- MAX_WRONG, 9, wrong guesses in one round that cause failure.
- CNT_W, 4, counter width; WIN_TARGET and MAX_WRONG must both be < 2^CNT_W.
- LFSR_SEED, 16'hACE1, nonzero reset value of the 16-bit LFSR.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a new game.
- mode_fixed  in  1  1 = use fixed_secret; 0 = use LFSR draw.
- fixed_secret  in  DATA_W  secret value used when mode_fixed=1.
- guess_valid  in  1  guess_data is valid.
- guess_data  in  DATA_W  binary guess.
- guess_ready  out  1  block can accept a guess.
- hint  out  2  0 none, 1 up (secret > guess), 2 down (secret < guess), 3 correct.
- hint_valid  out  1  one-cycle pulse when hint and counters update.
- guess_err  out  1  one-cycle pulse when a guess is > MAX_VAL.
- correct_cnt  out  CNT_W  correct rounds this game.
- wrong_cnt  out  CNT_W  wrong guesses in the current round.
- success  out  1  game won; held.
- fail  out  1  game lost; held.
- secret_dbg  out  DATA_W  current secret, for verification visibility.

Behaviour:
- Reset (async, low): state=IDLE. All outputs 0, including guess_ready. LFSR=LFSR_SEED.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Shifts every clock in every state except while reset is asserted.
- States: IDLE, ARM, WAIT, JUDGE, WIN, LOSE.
- start (any state, sampled on clk): clears hint, correct_cnt, wrong_cnt, success and fail, then goes to ARM. start has priority over a same-cycle guess handshake; that guess is dropped.
- ARM:
  - mode_fixed=1: secret = min(fixed_secret, MAX_VAL); go to WAIT after 1 cycle.
  - mode_fixed=0: candidate = LFSR[DATA_W-1:0]. If candidate ≤ MAX_VAL, latch it and go to WAIT; otherwise stay in ARM and retry next cycle (rejection sampling, no modulo).
  - guess_ready=0 in ARM.
- WAIT: guess_ready=1. A handshake occurs when guess_valid && guess_ready at a rising edge.
  - guess_data > MAX_VAL: pulse guess_err for the next cycle. No counter or hint change. Stay in WAIT.
  - Otherwise: register the guess and go to JUDGE. guess_ready drops in the following cycle.
- JUDGE: one cycle. At its closing edge, hint_valid=1 for the following cycle, and:
  - guess==secret: hint=3; correct_cnt+1; wrong_cnt=0. If the new correct_cnt == WIN_TARGET, go to WIN; else go to ARM and draw a new secret.
  - secret > guess: hint=1; wrong_cnt+1.
  - secret < guess: hint=2; wrong_cnt+1.
  - After a wrong guess: if the new wrong_cnt == MAX_WRONG, go to LOSE; else go to WAIT.
- Latency: guess accepted at edge E0; hint, counters and flags change at E1 = E0+1. hint_valid is high between E1 and E2. The earliest next acceptance is at E2.
- WIN: success=1. LOSE: fail=1. Both are terminal until start or reset. guess_ready=0; guesses are ignored with no guess_err.
- hint holds its last value between pulses; it is cleared only by start or reset.
- Counters never wrap: the WIN/LOSE transitions occur exactly at the thresholds.
- Reset mid-operation, including during JUDGE: immediate return to reset values; the pending guess is lost.
- guess_valid is ignored outside WAIT. The upstream source holds guess_valid/guess_data until guess_ready is seen.

Test Plan:
- Reset with no start → all outputs 0, guess_ready=0. Assert guess_valid with guess 5 → no hint_valid, no counter change.
- mode_fixed=1, fixed_secret=7, start.
  - Guess 3 → hint=1, wrong_cnt=1.
  - Guess 9 → hint=2, wrong_cnt=2.
  - Guess 7 → hint=3, correct_cnt=1, wrong_cnt=0.
  - Each hint_valid appears exactly 1 cycle after the acceptance edge.
- Fixed secret 7: three consecutive correct rounds → success=1 after the 3rd, guess_ready=0. A 4th guess is ignored and correct_cnt stays 3.
- Fixed secret 7: nine guesses of 0 → fail=1 at the 9th, with wrong_cnt=9 and hint=1. Then start → all cleared, block in ARM.
- Guess 12 (> MAX_VAL=9) in WAIT → guess_err pulse only; counters and hint unchanged; still in WAIT.
- mode_fixed=0, 1000 correct-driven rounds → secret_dbg always ≤ 9.
- Reset asserted during JUDGE → all outputs 0.
- start asserted in the same cycle as a handshake → guess dropped, counters 0.
